// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared FSM encoding and SPI frame constants for the arbiter.
package spi_bus_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_COMPLETE} arb_state_t;
    localparam int SPI_FRAME_W = 32;
    localparam logic [SPI_FRAME_W-1:0] RX_TIMEOUT_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// spi_rr_pick: combinational round-robin pick of the first pending index at or after the pointer.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index
);
    // Scan from the farthest offset down so the nearest pending index wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_pending[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_valid = 1'b1;
                o_index = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master among NUM_REQ sequencers,
// with a watchdog that abandons a transfer whose done never arrives.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                       i_sys_clock,
    input  logic                       i_sys_reset_n,
    input  logic [NUM_REQ-1:0]         i_req_start,
    input  logic [NUM_REQ*32-1:0]      i_req_tx,
    output logic [NUM_REQ-1:0]         o_req_done,
    output logic [NUM_REQ-1:0]         o_req_timeout,
    output logic [31:0]                o_req_rx,
    output logic [31:0]                o_spi_tx,
    output logic                       o_spi_start,
    input  logic                       i_spi_done,
    input  logic [31:0]                i_spi_rx,
    output logic                       o_bus_busy,
    output logic [IDX_W-1:0]           o_grant_index
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t             r_state, w_next;
    logic [NUM_REQ-1:0]     r_pending, w_clr;
    logic [IDX_W-1:0]       r_ptr, r_grant, w_pick_idx;
    logic                   w_pick_valid, w_grant, w_terminal, r_timeout;
    logic [CNT_W-1:0]       r_cnt;
    logic [31:0]            r_tx, r_rx, w_tx;

    spi_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_index   (w_pick_idx)
    );

    // A done still asserted from a previous or aborted transfer blocks new grants.
    assign w_grant    = (r_state == ST_IDLE) && w_pick_valid && !i_spi_done;
    assign w_terminal = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_tx       = i_req_tx[32'(w_pick_idx) * SPI_FRAME_W +: SPI_FRAME_W];
    assign w_clr      = w_grant ? NUM_REQ'(1) << w_pick_idx : '0;

    always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == ST_IDLE   ? (w_grant ? ST_LAUNCH : ST_IDLE) :
                 r_state == ST_LAUNCH ? ST_WAIT :
                 r_state == ST_WAIT   ? ((i_spi_done || w_terminal) ? ST_COMPLETE : ST_WAIT) :
                                        ST_IDLE;
    end

    always_comb begin
        o_spi_start   = r_state == ST_LAUNCH;
        o_bus_busy    = r_state != ST_IDLE;
        o_req_done    = (r_state == ST_COMPLETE) ? NUM_REQ'(1) << r_grant : '0;
        o_req_timeout = (r_state == ST_COMPLETE && r_timeout) ? NUM_REQ'(1) << r_grant : '0;
        o_spi_tx      = r_tx;
        o_req_rx      = r_rx;
        o_grant_index = r_grant;
    end

    always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | i_req_start;
            if (w_grant) begin
                r_tx    <= w_tx;
                r_grant <= w_pick_idx;
            end
            if (r_state == ST_LAUNCH) begin
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                if (i_spi_done)
                    r_rx <= i_spi_rx;
                else if (w_terminal) begin
                    r_rx      <= RX_TIMEOUT_WORD;
                    r_timeout <= 1'b1;
                end else
                    r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_COMPLETE)
                r_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed checks of the round-robin picker and the arbiter FSM,
// using a long-watchdog instance for normal traffic and a TIMEOUT_CYCLES=8 instance for watchdog cases.
module tb_spi_bus_arbiter;
    logic         clk, rst_n;
    logic [3:0]   req_start, start_b;
    logic [127:0] req_tx;
    logic         spi_done, done_b;
    logic [31:0]  spi_rx;
    logic [3:0]   req_done, req_to, done_o_b, to_b;
    logic [31:0]  req_rx, spi_tx, rx_b, tx_b;
    logic         spi_start, busy, start_o_b, busy_b;
    logic [1:0]   grant, grant_b;
    logic [3:0]   pk_pend;
    logic [1:0]   pk_ptr, pk_idx;
    logic         pk_valid;
    int           n_tests = 0;
    int           n_fail  = 0;

    spi_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .i_sys_clock(clk), .i_sys_reset_n(rst_n), .i_req_start(req_start), .i_req_tx(req_tx),
        .o_req_done(req_done), .o_req_timeout(req_to), .o_req_rx(req_rx), .o_spi_tx(spi_tx),
        .o_spi_start(spi_start), .i_spi_done(spi_done), .i_spi_rx(spi_rx), .o_bus_busy(busy),
        .o_grant_index(grant)
    );

    spi_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut_b (
        .i_sys_clock(clk), .i_sys_reset_n(rst_n), .i_req_start(start_b), .i_req_tx(req_tx),
        .o_req_done(done_o_b), .o_req_timeout(to_b), .o_req_rx(rx_b), .o_spi_tx(tx_b),
        .o_spi_start(start_o_b), .i_spi_done(done_b), .i_spi_rx(spi_rx), .o_bus_busy(busy_b),
        .o_grant_index(grant_b)
    );

    spi_rr_pick #(.NUM_REQ(4), .IDX_W(2)) u_pick (
        .i_pending(pk_pend), .i_ptr(pk_ptr), .o_valid(pk_valid), .o_index(pk_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pend;
        logic [1:0] ptr;
        logic       valid;
        logic [1:0] idx;
    } pick_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_start = '0; start_b = '0; spi_done = 1'b0; done_b = 1'b0;
        repeat (2) step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (spi_start !== 1'b1 && n < 40) begin step; n++; end
        check(nm, 32'(spi_start), 32'd1);
    endtask

    task automatic wait_start_b(input string nm);
        int n = 0;
        while (start_o_b !== 1'b1 && n < 40) begin step; n++; end
        check(nm, 32'(start_o_b), 32'd1);
    endtask

    // Waits for the launch, checks the grant, then completes after one WAIT cycle.
    task automatic serve(input int idx, input logic rereq0);
        wait_start($sformatf("start_%0d", idx));
        check($sformatf("grant_%0d", idx), 32'(grant), 32'(idx));
        check($sformatf("tx_%0d", idx), spi_tx, 32'hA000_0000 + 32'(idx));
        step;
        if (rereq0) req_start = 4'b0001;
        spi_done = 1'b1;
        spi_rx = 32'hB000_0000 + 32'(idx);
        step;
        req_start = '0;
        spi_done = 1'b0;
        check($sformatf("done_%0d", idx), 32'(req_done), 32'(4'b0001 << idx));
        check($sformatf("rx_%0d", idx), req_rx, 32'hB000_0000 + 32'(idx));
        check($sformatf("to_%0d", idx), 32'(req_to), 32'd0);
    endtask

    initial begin
        pick_vec_t vecs[10];
        int        order[5];
        int        starts;
        int        bad;
        vecs[0] = '{4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[1] = '{4'b0001, 2'd0, 1'b1, 2'd0};
        vecs[2] = '{4'b0001, 2'd1, 1'b1, 2'd0};
        vecs[3] = '{4'b1010, 2'd0, 1'b1, 2'd1};
        vecs[4] = '{4'b1010, 2'd2, 1'b1, 2'd3};
        vecs[5] = '{4'b1010, 2'd3, 1'b1, 2'd3};
        vecs[6] = '{4'b1111, 2'd2, 1'b1, 2'd2};
        vecs[7] = '{4'b0100, 2'd3, 1'b1, 2'd2};
        vecs[8] = '{4'b1000, 2'd1, 1'b1, 2'd3};
        vecs[9] = '{4'b0011, 2'd2, 1'b1, 2'd0};
        order = '{0, 1, 2, 3, 0};
        req_tx = '0; spi_rx = '0;
        req_start = '0; start_b = '0; spi_done = 1'b0; done_b = 1'b0; rst_n = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pk_pend = vecs[i].pend;
            pk_ptr  = vecs[i].ptr;
            #1;
            check($sformatf("pick_valid_%0d", i), 32'(pk_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) check($sformatf("pick_idx_%0d", i), 32'(pk_idx), 32'(vecs[i].idx));
        end

        do_reset;
        check("rst_tx", spi_tx, 32'd0);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_to", 32'(req_to), 32'd0);
        check("rst_rx", req_rx, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);

        // Single request from requester 2.
        req_tx[95:64] = 32'h1234_5678;
        req_start = 4'b0100;
        step;
        req_start = '0;
        check("single_no_early_start", 32'(spi_start), 32'd0);
        step;
        check("single_start", 32'(spi_start), 32'd1);
        check("single_tx", spi_tx, 32'h1234_5678);
        check("single_grant", 32'(grant), 32'd2);
        check("single_busy", 32'(busy), 32'd1);
        starts = 0;
        repeat (10) begin step; starts += int'(spi_start); end
        check("single_extra_starts", 32'(starts), 32'd0);
        spi_done = 1'b1; spi_rx = 32'hCAFE_0001;
        step;
        spi_done = 1'b0;
        check("single_done", 32'(req_done), 32'b0100);
        check("single_rx", req_rx, 32'hCAFE_0001);
        check("single_to", 32'(req_to), 32'd0);
        step;
        check("single_done_drop", 32'(req_done), 32'd0);
        check("single_idle", 32'(busy), 32'd0);
        check("single_rx_hold", req_rx, 32'hCAFE_0001);

        // Fairness: all four at once, requester 0 re-requests during requester 1's transfer.
        do_reset;
        for (int i = 0; i < 4; i++) req_tx[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        req_start = 4'b1111;
        step;
        req_start = '0;
        for (int k = 0; k < 5; k++) serve(order[k], k == 1);

        // Re-request during own COMPLETE, with the pointer wrapping past it.
        do_reset;
        req_start = 4'b0100;
        step;
        req_start = '0;
        serve(2, 1'b0);
        req_start = 4'b0100;
        step;
        req_start = '0;
        check("own_idle", 32'(spi_start), 32'd0);
        step;
        check("own_restart", 32'(spi_start), 32'd1);
        check("own_grant", 32'(grant), 32'd2);

        // Stale done held after COMPLETE while requester 1 is pending.
        do_reset;
        req_start = 4'b0001;
        step;
        req_start = '0;
        wait_start("stale_first_start");
        step;
        req_start = 4'b0010;
        spi_done = 1'b1;
        spi_rx = 32'h0000_00AA;
        step;
        req_start = '0;
        check("stale_first_done", 32'(req_done), 32'b0001);
        bad = 0;
        repeat (5) begin step; bad += int'(spi_start) + int'(busy); end
        check("stale_blocked", 32'(bad), 32'd0);
        spi_done = 1'b0;
        step;
        check("stale_start", 32'(spi_start), 32'd1);
        check("stale_grant", 32'(grant), 32'd1);
        step;
        spi_done = 1'b1; spi_rx = 32'h0000_00BB;
        step;
        spi_done = 1'b0;
        check("stale_done", 32'(req_done), 32'b0010);
        check("stale_rx", req_rx, 32'h0000_00BB);

        // Watchdog on the short-timeout instance, then done on the terminal cycle.
        do_reset;
        start_b = 4'b0011;
        step;
        start_b = '0;
        wait_start_b("to_start");
        check("to_grant", 32'(grant_b), 32'd0);
        repeat (8) step;
        check("to_not_early", 32'(done_o_b), 32'd0);
        step;
        check("to_done", 32'(done_o_b), 32'b0001);
        check("to_flag", 32'(to_b), 32'b0001);
        check("to_rx", rx_b, 32'hFFFF_FFFF);
        step;
        check("to_idle", 32'(busy_b), 32'd0);
        step;
        check("to_next_start", 32'(start_o_b), 32'd1);
        check("to_next_grant", 32'(grant_b), 32'd1);
        repeat (8) step;
        check("term_not_early", 32'(done_o_b), 32'd0);
        done_b = 1'b1; spi_rx = 32'h1357_9BDF;
        step;
        done_b = 1'b0;
        check("term_done", 32'(done_o_b), 32'b0010);
        check("term_no_to", 32'(to_b), 32'd0);
        check("term_rx", rx_b, 32'h1357_9BDF);

        // Asynchronous reset in the middle of WAIT.
        req_start = 4'b1000;
        step;
        req_start = 4'b0001;
        step;
        req_start = '0;
        wait_start("mid_start");
        step;
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_tx", spi_tx, 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_rx", req_rx, 32'd0);
        @(posedge clk);
        step;
        rst_n = 1'b1;
        spi_done = 1'b1;
        step;
        spi_done = 1'b0;
        bad = 0;
        repeat (10) begin step; bad += int'(req_done != 0) + int'(busy); end
        check("mid_quiet", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
